// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcodes, IEEE-754 constants and divider FSM encoding for the FPU slice.
package fpu_pkg;
  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] MUL = 4'b0010;
  localparam logic [3:0] DIV = 4'b0011;
  localparam int BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_e;
  function automatic logic [31:0] fp_inf(input logic s);
    return {s, 8'hFF, 23'h0};
  endfunction
  function automatic logic [31:0] fp_zero(input logic s);
    return {s, 31'h0};
  endfunction
endpackage

// File: rtl/fp_divider_seq_if.sv
// fp_divider_seq_if: start/busy/done request bus carrying operands, quotient and flags.
interface fp_divider_seq_if;
  logic start;
  logic [31:0] num1;
  logic [31:0] num2;
  logic busy;
  logic done;
  logic [31:0] result;
  logic [3:0] flags;
  modport master (output start, num1, num2, input busy, done, result, flags);
  modport slave (input start, num1, num2, output busy, done, result, flags);
endinterface

// File: rtl/fp_classify.sv
// fp_classify: zero/inf/nan detection for one single-precision operand; subnormals count as zero.
module fp_classify (
  input  logic [31:0] op_i,
  output logic        is_zero_o,
  output logic        is_inf_o,
  output logic        is_nan_o
);
  logic exp_max;
  assign exp_max = &op_i[30:23];
  assign is_zero_o = ~|op_i[30:23];
  assign is_inf_o = exp_max & ~|op_i[22:0];
  assign is_nan_o = exp_max & |op_i[22:0];
endmodule

// File: rtl/fp_divider_seq.sv
// fp_divider_seq: iterative single-precision divider, restoring radix-2, one quotient bit per clock,
// truncating rounding, subnormals flushed to zero.
module fp_divider_seq #(
  parameter int EXP_W = 8,
  parameter int MANT_W = 23,
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input logic clk,
  input logic rst,
  fp_divider_seq_if.slave bus
);
  import fpu_pkg::*;
  localparam int EW = EXP_W + 2;
  typedef logic signed [EW-1:0] exp_t;
  state_e state_q, state_d;
  logic sign_q, sign_d;
  exp_t exp_q, exp_d;
  logic [MANT_W+1:0] rem_q, rem_d, quo_q, quo_d;
  logic [MANT_W:0] div_q, div_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic [3:0] flags_q, flags_d;
  logic z1, i1, n1, z2, i2, n2;
  logic sign_in, special;
  logic [35:0] spec_w, norm_w;
  logic [MANT_W+1:0] diff;
  logic ge;
  logic [MANT_W-1:0] mant;
  exp_t exp_n;
  fp_classify u_cls1 (.op_i(bus.num1), .is_zero_o(z1), .is_inf_o(i1), .is_nan_o(n1));
  fp_classify u_cls2 (.op_i(bus.num2), .is_zero_o(z2), .is_inf_o(i2), .is_nan_o(n2));
  assign sign_in = bus.num1[31] ^ bus.num2[31];
  assign special = n1 | n2 | i1 | i2 | z1 | z2;
  assign spec_w = (n1 | n2 | (i1 & i2) | (z1 & z2)) ? {4'b1000, QNAN} :
                  i1 ? {4'b0000, fp_inf(sign_in)} :
                  i2 ? {4'b0000, fp_zero(sign_in)} :
                  z2 ? {4'b0100, fp_inf(sign_in)} : {4'b0000, fp_zero(sign_in)};
  // rem stays below 2*div, so the borrow bit of the trial subtraction is the compare result
  assign diff = rem_q - {1'b0, div_q};
  assign ge = ~diff[MANT_W+1];
  assign mant = quo_q[MANT_W+1] ? quo_q[MANT_W:1] : quo_q[MANT_W-1:0];
  assign exp_n = quo_q[MANT_W+1] ? exp_q : exp_q - exp_t'(1);
  assign norm_w = (exp_n >= exp_t'(EXP_MAX)) ? {4'b0010, fp_inf(sign_q)} :
                  (exp_n <= exp_t'(0)) ? {4'b0001, fp_zero(sign_q)} :
                  {4'b0000, sign_q, exp_n[EXP_W-1:0], mant};
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    exp_d = exp_q;
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    cnt_d = cnt_q;
    res_d = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: if (bus.start) begin
        sign_d = sign_in;
        if (special) begin
          {flags_d, res_d} = spec_w;
          state_d = DONE;
        end else begin
          rem_d = {2'b01, bus.num1[MANT_W-1:0]};
          div_d = {1'b1, bus.num2[MANT_W-1:0]};
          quo_d = '0;
          cnt_d = '0;
          exp_d = exp_t'({2'b00, bus.num1[MANT_W+EXP_W-1:MANT_W]})
                - exp_t'({2'b00, bus.num2[MANT_W+EXP_W-1:MANT_W]}) + exp_t'(BIAS);
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = {ge ? diff[MANT_W:0] : rem_q[MANT_W:0], 1'b0};
        quo_d = {quo_q[MANT_W:0], ge};
        cnt_d = cnt_q + 5'd1;
        state_d = (cnt_q == 5'(MANT_W + 1)) ? NORM : DIVIDE;
      end
      NORM: begin
        {flags_d, res_d} = norm_w;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      exp_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      flags_q <= flags_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.result = res_q;
  assign bus.flags = flags_q;
endmodule
